// File: rtl/tpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tpu_pkg
// Purpose  : Shared constants and types for the TPU tile control path.
// Revision : 1.0 - initial release
// ============================================================================
package tpu_pkg;

  // Array geometry feeding the pipeline-latency derivation
  localparam int MATRIX_SIZE = 8;
  localparam int NUM_PE_ROWS = 8;

  // UB read (1) + input skew and output deskew (2*(N-1)) + array rows
  localparam int PIPE_LAT_DEFAULT = 1 + 2 * (MATRIX_SIZE - 1) + NUM_PE_ROWS;

  // Default port widths
  localparam int ADDRESSSIZE_DEFAULT = 10;
  localparam int WADDR_BW_DEFAULT    = 2;
  localparam int CNT_BW_DEFAULT      = 10;

  // Tile sequencer states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WADDR  = 3'd1,
    ST_WLOAD  = 3'd2,
    ST_STREAM = 3'd3,
    ST_DRAIN  = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

endpackage
`default_nettype wire

// File: rtl/tpu_valid_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tpu_valid_pipe
// Purpose  : DEPTH-stage 1-bit shift register tracking in-flight activations.
//            tail fires DEPTH cycles after din; near_tail one cycle earlier;
//            pending flags any bit that has not yet reached the tail.
// Revision : 1.0 - initial release
// ============================================================================
module tpu_valid_pipe #(
  parameter int DEPTH = 23
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic tail,
  output logic near_tail,
  output logic pending
);

  logic [DEPTH-1:0] stages;

  // Shift valid bits toward the tail; reset clears everything in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stages <= '0;
    end else begin
      stages <= {stages[DEPTH-2:0], din};
    end
  end

  assign tail      = stages[DEPTH-1];
  assign near_tail = stages[DEPTH-2];
  // Excludes the tail so the owner can finish in the same cycle as the last write
  assign pending   = |stages[DEPTH-2:0];

endmodule
`default_nettype wire

// File: rtl/tpu_tile_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tpu_tile_sequencer
// Purpose  : Turns one start command into the weight load, activation stream,
//            pipeline drain and result writes for a single tile.
// Revision : 1.0 - initial release
// ============================================================================
module tpu_tile_sequencer
  import tpu_pkg::*;
#(
  parameter int ADDRESSSIZE = ADDRESSSIZE_DEFAULT,
  parameter int WADDR_BW    = WADDR_BW_DEFAULT,
  parameter int CNT_BW      = CNT_BW_DEFAULT,
  parameter int PIPE_LAT    = PIPE_LAT_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [ADDRESSSIZE-1:0] ub_base,
  input  logic [ADDRESSSIZE-1:0] res_base,
  input  logic [CNT_BW-1:0]      num_vec,
  input  logic [WADDR_BW-1:0]    w_tile,
  output logic                   busy,
  output logic                   end_,
  output logic [ADDRESSSIZE-1:0] ub_address,
  output logic                   ub_rd,
  output logic [WADDR_BW-1:0]    fifo_address,
  output logic                   we_rl,
  output logic                   res_we,
  output logic [ADDRESSSIZE-1:0] res_address
);

  state_t                 state;
  logic [ADDRESSSIZE-1:0] ub_base_r;
  logic [ADDRESSSIZE-1:0] res_base_r;
  logic [CNT_BW-1:0]      num_vec_r;
  logic [CNT_BW-1:0]      issue_cnt;
  logic [CNT_BW-1:0]      res_cnt;
  logic                   pipe_tail;
  logic                   pipe_near_tail;
  logic                   pipe_pending;

  // Control FSM; every output is registered together with the state it belongs to
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      busy         <= 1'b0;
      end_         <= 1'b0;
      ub_rd        <= 1'b0;
      we_rl        <= 1'b0;
      ub_address   <= '0;
      fifo_address <= '0;
      ub_base_r    <= '0;
      res_base_r   <= '0;
      num_vec_r    <= '0;
      issue_cnt    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            ub_base_r    <= ub_base;
            res_base_r   <= res_base;
            num_vec_r    <= num_vec;
            fifo_address <= w_tile;
            busy         <= 1'b1;
            state        <= ST_WADDR;
          end
        end
        ST_WADDR: begin
          // Weight SRAM data is valid now; tell the array to latch it
          we_rl <= 1'b1;
          state <= ST_WLOAD;
        end
        ST_WLOAD: begin
          we_rl <= 1'b0;
          if (num_vec_r != '0) begin
            ub_rd      <= 1'b1;
            ub_address <= ub_base_r;
            issue_cnt  <= CNT_BW'(1);
            state      <= ST_STREAM;
          end else begin
            end_  <= 1'b1;
            state <= ST_DONE;
          end
        end
        ST_STREAM: begin
          // issue_cnt counts addresses already on the bus, including this cycle's
          if (issue_cnt == num_vec_r) begin
            ub_rd <= 1'b0;
            state <= ST_DRAIN;
          end else begin
            ub_address <= ub_base_r + ADDRESSSIZE'(issue_cnt);
            issue_cnt  <= issue_cnt + CNT_BW'(1);
          end
        end
        ST_DRAIN: begin
          if (!pipe_pending) begin
            end_  <= 1'b1;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          end_  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Result address steps one cycle ahead so it lines up with the matching res_we
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_cnt     <= '0;
      res_address <= '0;
    end else if (state == ST_IDLE && start) begin
      res_cnt <= '0;
    end else if (pipe_near_tail) begin
      res_address <= res_base_r + ADDRESSSIZE'(res_cnt);
      res_cnt     <= res_cnt + CNT_BW'(1);
    end
  end

  tpu_valid_pipe #(
    .DEPTH(PIPE_LAT)
  ) u_valid_pipe (
    .clk      (clk),
    .rst      (rst),
    .din      (ub_rd),
    .tail     (pipe_tail),
    .near_tail(pipe_near_tail),
    .pending  (pipe_pending)
  );

  assign res_we = pipe_tail;

endmodule
`default_nettype wire

// File: tb/tb_tpu_tile_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_tpu_tile_sequencer
// Purpose  : Directed bench with a cycle-indexed expectation model for the
//            tile sequencer plus literal spot checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tpu_tile_sequencer;

  localparam int AW   = 10;
  localparam int WW   = 2;
  localparam int CW   = 10;
  localparam int LAT  = 1 + 7 + 8 + 7;
  localparam int MAXC = 2048;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] ub_base = '0;
  logic [AW-1:0] res_base = '0;
  logic [CW-1:0] num_vec = '0;
  logic [WW-1:0] w_tile = '0;
  logic          busy, end_, ub_rd, we_rl, res_we;
  logic [AW-1:0] ub_address, res_address;
  logic [WW-1:0] fifo_address;

  tpu_tile_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .ub_base     (ub_base),
    .res_base    (res_base),
    .num_vec     (num_vec),
    .w_tile      (w_tile),
    .busy        (busy),
    .end_        (end_),
    .ub_address  (ub_address),
    .ub_rd       (ub_rd),
    .fifo_address(fifo_address),
    .we_rl       (we_rl),
    .res_we      (res_we),
    .res_address (res_address)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  int errors = 0;
  int checks = 0;
  int busy_till = -1;
  bit chk_en = 1'b0;

  // Expected events per cycle
  bit            e_busy[MAXC], e_end[MAXC], e_we[MAXC], e_rd[MAXC];
  bit            e_rwe[MAXC], e_fset[MAXC], e_rst[MAXC];
  logic [AW-1:0] e_uba[MAXC], e_ra[MAXC];
  logic [WW-1:0] e_fa[MAXC];

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s cycle=%0d got=0x%0h exp=0x%0h", name, c, act, exp);
    end
  endtask

  function automatic int tile_len(input int n);
    return (n == 0) ? 3 : 3 + n + LAT;
  endfunction

  // Lay out the whole tile's expected activity relative to its start cycle
  task automatic plan(input int c0, input int ub, input int rb, input int n, input int w);
    int t;
    t = tile_len(n);
    for (int k = 1; k <= t; k++) if (c0 + k < MAXC) e_busy[c0 + k] = 1'b1;
    e_fset[c0 + 1] = 1'b1;
    e_fa[c0 + 1]   = WW'(w);
    e_we[c0 + 2]   = 1'b1;
    for (int i = 0; i < n; i++) begin
      if (c0 + 3 + i + LAT < MAXC) begin
        e_rd[c0 + 3 + i]        = 1'b1;
        e_uba[c0 + 3 + i]       = AW'((ub + i) % (1 << AW));
        e_rwe[c0 + 3 + i + LAT] = 1'b1;
        e_ra[c0 + 3 + i + LAT]  = AW'((rb + i) % (1 << AW));
      end
    end
    if (c0 + t < MAXC) e_end[c0 + t] = 1'b1;
    busy_till = c0 + t;
  endtask

  task automatic model_reset(input int c);
    for (int k = c; k < MAXC; k++) begin
      e_busy[k] = 1'b0; e_end[k] = 1'b0; e_we[k] = 1'b0; e_rd[k] = 1'b0;
      e_rwe[k]  = 1'b0; e_fset[k] = 1'b0; e_rst[k] = 1'b0;
    end
    e_rst[c]  = 1'b1;
    busy_till = -1;
  endtask

  // Per-cycle comparison against the model
  initial begin
    logic [AW-1:0] cur_uba, cur_ra;
    logic [WW-1:0] cur_fa;
    int c;
    cur_uba = '0; cur_ra = '0; cur_fa = '0;
    forever begin
      @(negedge clk);
      if (chk_en && cyc < MAXC) begin
        c = cyc;
        if (e_rst[c]) begin cur_uba = '0; cur_ra = '0; cur_fa = '0; end
        if (e_fset[c]) cur_fa  = e_fa[c];
        if (e_rd[c])   cur_uba = e_uba[c];
        if (e_rwe[c])  cur_ra  = e_ra[c];
        chk("busy", c, busy, e_busy[c]);
        chk("end_", c, end_, e_end[c]);
        chk("we_rl", c, we_rl, e_we[c]);
        chk("ub_rd", c, ub_rd, e_rd[c]);
        chk("res_we", c, res_we, e_rwe[c]);
        chk("ub_address", c, ub_address, cur_uba);
        chk("res_address", c, res_address, cur_ra);
        chk("fifo_address", c, fifo_address, cur_fa);
      end
    end
  end

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic at(input int c);
    goto(c);
    @(negedge clk);
  endtask

  task automatic do_start(input int ub, input int rb, input int n, input int w, output int c0);
    start    = 1'b1;
    ub_base  = AW'(ub);
    res_base = AW'(rb);
    num_vec  = CW'(n);
    w_tile   = WW'(w);
    c0       = cyc;
    if (c0 > busy_till) plan(c0, ub, rb, n, w);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cycle=%0d got=timeout exp=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, c1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst    = 1'b0;
    chk_en = 1'b1;

    // Reset state then idle
    at(cyc);
    chk("lit_reset_busy", cyc, busy, 0);
    chk("lit_reset_ub_rd", cyc, ub_rd, 0);
    goto(cyc + 100);

    // Basic tile
    goto(cyc + 1);
    do_start('h010, 'h200, 8, 2, c0);
    at(c0 + 1);  chk("lit_basic_fifo", cyc, fifo_address, 2);
    at(c0 + 2);  chk("lit_basic_we_rl", cyc, we_rl, 1);
    at(c0 + 3);  chk("lit_basic_ub_first", cyc, ub_address, 'h010);
    at(c0 + 10); chk("lit_basic_ub_last", cyc, ub_address, 'h017);
    at(c0 + 26); chk("lit_basic_res_we", cyc, res_we, 1);
                 chk("lit_basic_res_first", cyc, res_address, 'h200);
    at(c0 + 33); chk("lit_basic_res_last", cyc, res_address, 'h207);
    at(c0 + 34); chk("lit_basic_end", cyc, end_, 1);
    at(c0 + 35); chk("lit_basic_idle", cyc, busy, 0);

    // Address wrap-around
    goto(cyc + 2);
    do_start('h3FE, 'h3FF, 3, 1, c0);
    at(c0 + 5);  chk("lit_wrap_ub", cyc, ub_address, 'h000);
    at(c0 + 26); chk("lit_wrap_res0", cyc, res_address, 'h3FF);
    at(c0 + 28); chk("lit_wrap_res2", cyc, res_address, 'h001);
    at(c0 + 29); chk("lit_wrap_end", cyc, end_, 1);

    // Zero-length tile followed by a back-to-back start
    goto(cyc + 2);
    do_start('h100, 'h100, 0, 3, c0);
    at(c0 + 2);  chk("lit_zero_we_rl", cyc, we_rl, 1);
    at(c0 + 3);  chk("lit_zero_end", cyc, end_, 1);
    goto(c0 + 4);
    do_start('h020, 'h300, 2, 0, c1);
    at(c1 + 3);  chk("lit_b2b_ub", cyc, ub_address, 'h020);
    at(c1 + 28); chk("lit_b2b_end", cyc, end_, 1);

    // Start while busy is ignored
    goto(cyc + 2);
    do_start('h040, 'h080, 4, 1, c0);
    goto(c0 + 5);
    do_start('h1F0, 'h1F0, 9, 3, c1);
    at(c0 + 6);  chk("lit_busy_fifo_kept", cyc, fifo_address, 1);
    at(c0 + 29); chk("lit_busy_res_last", cyc, res_address, 'h083);
    at(c0 + 30); chk("lit_busy_end", cyc, end_, 1);
    at(c0 + 31); chk("lit_busy_idle", cyc, busy, 0);

    // Reset five cycles into DRAIN, then a normal tile
    goto(cyc + 2);
    do_start('h050, 'h060, 4, 2, c0);
    goto(c0 + 12);
    rst = 1'b1;
    model_reset(cyc);
    at(c0 + 12); chk("lit_rst_busy", cyc, busy, 0);
    goto(c0 + 14);
    rst = 1'b0;
    goto(c0 + 16);
    do_start('h070, 'h010, 1, 1, c1);
    at(c1 + 26); chk("lit_post_rst_res", cyc, res_address, 'h010);
    at(c1 + 27); chk("lit_post_rst_end", cyc, end_, 1);
    goto(cyc + 5);

    @(negedge clk);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
